// File: rtl/rapcore_wb_ctrl.sv
// rapcore_wb_ctrl: Wishbone register block sequencing rapcore reset release and pad output enables.
module rapcore_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned RESET_CYCLES = 16384,
    parameter logic [37:0] OEB_DEFAULT  = 38'h3F_FFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_rst_valid,
    input  logic        la_rst_req,
    input  logic        move_done_i,
    input  logic        buffer_dtr_i,
    output logic        core_resetn,
    output logic [37:0] io_oeb_o
);
    typedef enum logic [1:0] {OFF = 2'd0, HOLD = 2'd1, RUN = 2'd2} state_e;
    localparam logic [15:0] LEN_RST = 16'(RESET_CYCLES);
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        en_q, en_d;
    logic        soft_q, soft_d;
    logic [15:0] len_q, len_d;
    logic [37:0] oeb_q, oeb_d;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        resetn_q;
    logic        in_win, wr;
    logic [2:0]  idx;
    logic [31:0] wmask, rdata;
    logic [15:0] len_w;
    logic        unused_ok;

    assign in_win    = wbs_adr_i[31:5] == BASE_ADDR[31:5];
    assign ack_d     = in_win & wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr        = ack_d & wbs_we_i;
    assign idx       = wbs_adr_i[4:2];
    assign wmask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign len_w     = (len_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
    assign unused_ok = &{1'b0, wbs_adr_i[1:0]};

    always_comb begin
        case (idx)
            3'd0:    rdata = {31'b0, en_q};
            3'd1:    rdata = {27'b0, buffer_dtr_i, move_done_i, state_q, resetn_q};
            3'd2:    rdata = oeb_q[31:0];
            3'd3:    rdata = {26'b0, oeb_q[37:32]};
            3'd4:    rdata = {16'b0, len_q};
            default: rdata = 32'b0;
        endcase
        dat_d = ack_d ? rdata : 32'b0;
    end

    always_comb begin
        en_d   = en_q;
        soft_d = 1'b0;
        oeb_d  = oeb_q;
        len_d  = len_q;
        if (wr) begin
            case (idx)
                3'd0: begin
                    en_d   = wbs_sel_i[0] ? wbs_dat_i[0] : en_q;
                    soft_d = wbs_sel_i[0] & wbs_dat_i[1];
                end
                3'd2:    oeb_d[31:0]  = (oeb_q[31:0] & ~wmask) | (wbs_dat_i & wmask);
                3'd3:    oeb_d[37:32] = (oeb_q[37:32] & ~wmask[5:0]) | (wbs_dat_i[5:0] & wmask[5:0]);
                3'd4:    len_d        = (len_w == 16'd0) ? 16'd1 : len_w;
                default: ;
            endcase
        end
    end

    // Priority: LA request, then ENABLE=0, then soft reset / initial load, then completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (la_rst_valid && la_rst_req) begin
            state_d = HOLD;
            cnt_d   = len_q;
        end else if (!en_q) begin
            state_d = OFF;
        end else if (state_q == OFF || soft_q) begin
            state_d = HOLD;
            cnt_d   = len_q;
        end else if (state_q == HOLD) begin
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? RUN : HOLD;
        end else if (state_q != RUN) begin
            state_d = OFF;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'b0;
            en_q     <= 1'b0;
            soft_q   <= 1'b0;
            len_q    <= LEN_RST;
            oeb_q    <= OEB_DEFAULT;
            state_q  <= OFF;
            cnt_q    <= 16'd0;
            resetn_q <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            soft_q   <= soft_d;
            len_q    <= len_d;
            oeb_q    <= oeb_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resetn_q <= state_d == RUN;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign core_resetn = resetn_q;
    assign io_oeb_o    = oeb_q;
endmodule

// File: doc/rapcore_wb_ctrl.md
# rapcore_wb_ctrl

Wishbone-controlled sequencer for the rapcore motor-control core inside the Caravel user area. It owns three things:
- the core's reset release, through a power-on/soft-reset stretch FSM;
- the per-pad output-enable vector for all 38 user IOs;
- a status readback path.

Logic-analyzer reset requests share reset control with the management SoC under fixed priority. It replaces hard-wired pad directions and the free-running reset counter in the user-project top level.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, word-aligned base of the 32-byte register window
- RESET_CYCLES, 16384, reset value of RESET_LEN; must be 1..65535
- OEB_DEFAULT, 38'h3F_FFFF_FFFF, io_oeb_o value after reset (all pads input)

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write enable
- wbs_sel_i  in  4  byte-lane select
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_rst_valid  in  1  the LA owns the reset request, active when the LA drives the probe
- la_rst_req  in  1  LA reset request; acts only when la_rst_valid=1
- move_done_i, buffer_dtr_i  in  1 each  core status, sampled into STATUS
- core_resetn  out  1  registered active-low reset to rapcore
- io_oeb_o  out  38  pad output enables (0 = output)

## Operation
Register map (offsets from BASE_ADDR):
- 0x00 CTRL
  - bit0 ENABLE, read/write.
  - bit1 SOFT_RST: write-1 pulse, always reads 0.
- 0x04 STATUS, read-only
  - bit0 core_resetn.
  - bits[2:1] state: OFF=0, HOLD=1, RUN=2.
  - bit3 move_done_i.
  - bit4 buffer_dtr_i.
- 0x08 OEB_LO, [31:0] = io_oeb_o[31:0].
- 0x0C OEB_HI, [5:0] = io_oeb_o[37:32]; upper bits read 0.
- 0x10 RESET_LEN, [15:0]; a written 0 is stored as 1.
- 0x14–0x1C: read 0, writes ignored, still acknowledged.

Addressing and writes:
- An address is "in window" when wbs_adr_i[31:5] == BASE_ADDR[31:5].
- Out-of-window accesses are never acknowledged and have no effect.
- Writes apply per byte lane where wbs_sel_i[n]=1.

Reset FSM (state register plus 16-bit down-counter):
- OFF: core_resetn=0.
  - ENABLE=1 → HOLD, with the counter loaded from RESET_LEN.
- HOLD: core_resetn=0; the counter decrements each cycle.
  - Counter==1 → RUN.
  - ENABLE=0 → OFF; this takes priority over completion.
- RUN: core_resetn=1.
  - ENABLE=0 → OFF.
  - SOFT_RST write with ENABLE=1 → HOLD, counter reloaded.

Priorities:
- LA override: la_rst_valid & la_rst_req forces HOLD and reloads the counter every cycle it is asserted, even when ENABLE=0.
  - On release, normal rules apply: completion requires ENABLE=1, otherwise → OFF the next cycle.
- Simultaneous events: wb_rst_i > LA request > ENABLE=0 > SOFT_RST > counter completion.
- A RESET_LEN write during HOLD does not affect the running count; it applies on the next load.
- A SOFT_RST written in OFF is ignored.

## Timing
Reset values (after wb_rst_i):
- state OFF, core_resetn=0, wbs_ack_o=0, wbs_dat_o=0.
- ENABLE=0, RESET_LEN=RESET_CYCLES, io_oeb_o=OEB_DEFAULT.
- wb_rst_i mid-HOLD or mid-RUN drops core_resetn to 0 on the next edge.

Wishbone handshake:
- wbs_ack_o rises on the edge after in-window stb&cyc is seen with ack=0.
- It is a one-cycle pulse. A held strobe yields one acknowledge every 2 cycles.
- Read data is registered and valid in the ack cycle; wbs_dat_o=0 when ack=0.
- Writes take effect on the same edge that raises ack. CTRL effects reach the FSM state one cycle later.

Reset-release latency:
- core_resetn goes high exactly RESET_LEN cycles after the first cycle in HOLD.
- With RESET_LEN=1, it is high one cycle after HOLD is entered.
- core_resetn and io_oeb_o are pure register outputs, with no combinational path from the bus.

## Test plan
- Reset, then read each register → CTRL=0, STATUS=0, OEB_LO=0xFFFF_FFFF, OEB_HI=0x3F, RESET_LEN=16384; every ack is exactly one cycle wide.
- Write RESET_LEN=5, then CTRL=1 → STATUS state=1 for 5 cycles; core_resetn rises exactly 5 cycles after HOLD entry; state=2.
- In RUN, pulse la_rst_valid=la_rst_req=1 for 3 cycles → core_resetn=0 on the next edge; it returns high 5 cycles after the request drops.
- In HOLD, write CTRL=0 in the same cycle the counter reaches 1 → state OFF, core_resetn stays 0.
- Write OEB_LO=0x0000_00FF with sel=4'b0001 → io_oeb_o[7:0] unchanged, [31:8] unchanged, readback 0xFFFF_FFFF. Then write 0x0 with sel=4'b0001 → io_oeb_o[7:0]=0.
- Access at BASE_ADDR+0x40, and a RESET_LEN write of 0 → no ack for the first; for the second, RESET_LEN reads back 1 and the release takes 1 cycle.
